// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared op-codes, FSM encoding and default widths for the ALU
//            issue stage and its register file.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_ADDR_W = 3;
    localparam int ALU_REG_N  = 8;
    localparam int ALU_IMM_W  = 16;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Op-codes 000 and 111 have no ALU function behind them.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Purpose  : REG_N x DATA_W register file. Two asynchronous operand read
//            ports, one asynchronous debug read port, one synchronous write
//            port. r0 is hardwired to zero; contents clear on async reset.
// Revision : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_N  = ALU_REG_N,
    parameter int ADDR_W = ALU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_rs1_data,
    output logic [DATA_W-1:0] o_rs2_data,
    output logic [DATA_W-1:0] o_dbg_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] w_regs [REG_N];

    // r0 has no storage, so writes to it vanish and reads return zero.
    assign w_regs[0] = '0;

    for (genvar gi = 1; gi < REG_N; gi++) begin : g_reg
        logic [DATA_W-1:0] data_q;
        logic [DATA_W-1:0] data_d;

        // Next value: take write data when this entry is addressed.
        always_comb begin
            data_d = data_q;
            if (i_wr_en && (i_wr_addr == ADDR_W'(gi))) begin
                data_d = i_wr_data;
            end
        end

        // Storage flop, cleared on reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign w_regs[gi] = data_q;
    end

    assign o_rs1_data = w_regs[i_rs1_addr];
    assign o_rs2_data = w_regs[i_rs2_addr];
    assign o_dbg_data = w_regs[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Multi-cycle operand/issue stage for an external combinational
//            32-bit ALU. IDLE -> READ -> EXEC -> WB, accepting a new
//            instruction in IDLE or WB. Drives registered A/B/sel, captures
//            O/Z, writes back and keeps a sticky zero flag.
// Options  : ALU_OPCHECK_EN - flag op-codes 000/111, suppress their write-back
//            and pulse err in WB. Undefined: ops pass through, err tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_N  = ALU_REG_N,
    parameter int ADDR_W = ALU_ADDR_W,
    parameter int IMM_W  = ALU_IMM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_use_imm,
    input  logic [IMM_W-1:0]  in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_o,
    input  logic              alu_z,
    output logic              done,
    output logic              z_flag,
    output logic              err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state_q,   state_d;
    logic [2:0]        op_q,      op_d;
    logic [ADDR_W-1:0] rd_q,      rd_d;
    logic [ADDR_W-1:0] rs1_q,     rs1_d;
    logic [ADDR_W-1:0] rs2_q,     rs2_d;
    logic              use_imm_q, use_imm_d;
    logic [IMM_W-1:0]  imm_q,     imm_d;
    logic [DATA_W-1:0] alu_a_q,   alu_a_d;
    logic [DATA_W-1:0] alu_b_q,   alu_b_d;
    logic [2:0]        alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic              res_z_q,   res_z_d;
    logic              z_flag_q,  z_flag_d;

    logic              w_accept;
    logic              w_illegal;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic [DATA_W-1:0] w_imm_sext;

    assign in_ready   = (state_q == IDLE) || (state_q == WB);
    assign w_accept   = in_valid && in_ready;
    assign w_imm_sext = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

`ifdef ALU_OPCHECK_EN
    logic illegal_q, illegal_d;

    // Classify the op once at accept; it rides along with the instruction.
    always_comb begin
        illegal_d = illegal_q;
        if (w_accept) begin
            illegal_d = op_is_illegal(in_op);
        end
    end

    // Illegal-op marker flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign w_illegal = illegal_q;
    assign err       = (state_q == WB) && illegal_q;
`else
    assign w_illegal = 1'b0;
    assign err       = 1'b0;
`endif

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rs1_addr (rs1_q),
        .i_rs2_addr (rs2_q),
        .i_dbg_addr (dbg_addr),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .o_dbg_data (dbg_data),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (rd_q),
        .i_wr_data  (result_q)
    );

    // Next-state, instruction latch, operand load, result capture, write-back.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        imm_d     = imm_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        result_d  = result_q;
        res_z_d   = res_z_q;
        z_flag_d  = z_flag_q;
        w_wr_en   = 1'b0;

        if (w_accept) begin
            op_d      = in_op;
            rd_d      = in_rd;
            rs1_d     = in_rs1;
            rs2_d     = in_rs2;
            use_imm_d = in_use_imm;
            imm_d     = in_imm;
        end

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = READ;
                end
            end
            READ: begin
                alu_a_d   = w_rs1_data;
                alu_b_d   = use_imm_q ? w_imm_sext : w_rs2_data;
                alu_sel_d = w_illegal ? OP_NOP : op_q;
                state_d   = EXEC;
            end
            EXEC: begin
                result_d = alu_o;
                res_z_d  = alu_z;
                state_d  = WB;
            end
            WB: begin
                // The write lands on the same edge that may accept the next
                // instruction, so its READ already sees the new value.
                if (!w_illegal) begin
                    w_wr_en  = (rd_q != '0);
                    z_flag_d = res_z_q;
                end
                state_d = w_accept ? READ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            result_q  <= '0;
            res_z_q   <= 1'b0;
            z_flag_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            result_q  <= result_d;
            res_z_q   <= res_z_d;
            z_flag_q  <= z_flag_d;
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;
    assign done    = (state_q == WB);
    assign z_flag  = z_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Self-checking bench for alu_issue_stage with an external ALU
//            model, a directed vector table, reset-abort and illegal-op
//            sequences, and randomized instructions against an
//            instruction-level register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

`ifdef ALU_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [2:0]  in_rd = '0;
    logic [2:0]  in_rs1 = '0;
    logic [2:0]  in_rs2 = '0;
    logic        in_use_imm = 1'b0;
    logic [15:0] in_imm = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_o;
    logic        alu_z;
    logic        done;
    logic        z_flag;
    logic        err;
    logic [2:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_o      (alu_o),
        .alu_z      (alu_z),
        .done       (done),
        .z_flag     (z_flag),
        .err        (err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Behavioural 32-bit ALU, also used by the instruction-level model.
    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b011:  return a & b;
            3'b100:  return a ^ b;
            3'b101:  return a << b[4:0];
            3'b110:  return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    assign alu_o = alu_fn(alu_sel, alu_a, alu_b);
    assign alu_z = (alu_o == 32'd0);

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_regs [8];
    logic        ref_z;

    logic        pend_valid = 1'b0;
    logic [2:0]  pend_rd;
    logic [31:0] pend_val;
    logic        pend_z;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: update architectural state, return what the
    // destination register, zero flag and err pulse should show.
    task automatic model_step(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                              input logic [2:0] rs2, input logic use_imm, input logic [15:0] imm,
                              output logic [31:0] val, output logic z, output logic e);
        logic [31:0] a, b, r;
        a = ref_regs[rs1];
        b = use_imm ? {{16{imm[15]}}, imm} : ref_regs[rs2];
        if (OPCHECK && (op == 3'b000 || op == 3'b111)) begin
            e = 1'b1;
        end else begin
            e = 1'b0;
            r = alu_fn(op, a, b);
            if (rd != 3'd0) ref_regs[rd] = r;
            ref_z = (r == 32'd0);
        end
        val = ref_regs[rd];
        z   = ref_z;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_regs[i] = 32'd0;
        ref_z = 1'b0;
    endtask

    // Compare the previous instruction's retired state once its write edge has passed.
    task automatic check_pending();
        if (pend_valid) begin
            dbg_addr = pend_rd;
            #1;
            check32("reg_writeback", dbg_data, pend_val);
            check1("z_flag", z_flag, pend_z);
            pend_valid = 1'b0;
        end
    endtask

    // Issue one instruction: entered after an edge with the stage in IDLE or WB,
    // returns one time-step into the instruction's WB cycle.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic use_imm, input logic [15:0] imm,
                             input logic [31:0] exp_val, input logic exp_z, input logic exp_err);
        check1("in_ready_accept", in_ready, 1'b1);
        in_valid   = 1'b1;
        in_op      = op;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = use_imm;
        in_imm     = imm;
        @(posedge clk); #1;
        // READ: upstream keeps offering junk that must be ignored
        in_op      = 3'($urandom_range(7, 0));
        in_rd      = 3'($urandom_range(7, 0));
        in_rs1     = 3'($urandom_range(7, 0));
        in_rs2     = 3'($urandom_range(7, 0));
        in_use_imm = 1'($urandom_range(1, 0));
        in_imm     = 16'($urandom);
        check1("done_read", done, 1'b0);
        check1("in_ready_busy", in_ready, 1'b0);
        check_pending();
        @(posedge clk); #1;
        check1("done_exec", done, 1'b0);
        check1("err_exec", err, 1'b0);
        check32("alu_sel_exec", 32'(alu_sel), 32'(exp_err ? 3'b000 : op));
        @(posedge clk); #1;
        check1("done_wb", done, 1'b1);
        check1("err_wb", err, exp_err);
        in_valid   = 1'b0;
        pend_valid = 1'b1;
        pend_rd    = rd;
        pend_val   = exp_val;
        pend_z     = exp_z;
    endtask

    task automatic drain();
        @(posedge clk); #1;
        check_pending();
        check1("done_after_wb", done, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        use_imm;
        logic [15:0] imm;
        logic [31:0] exp_val;
        logic        exp_z;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ev;
        logic        ez, ee;
        logic [2:0]  r_op, r_rd, r_rs1, r_rs2;
        logic        r_ui;
        logic [15:0] r_imm;

        vecs[0]  = '{3'b001, 3'd1, 3'd0, 3'd0, 1'b1, 16'd20,    32'd20,        1'b0};
        vecs[1]  = '{3'b001, 3'd2, 3'd0, 3'd0, 1'b1, 16'd5,     32'd5,         1'b0};
        vecs[2]  = '{3'b010, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0,     32'd15,        1'b0};
        vecs[3]  = '{3'b010, 3'd4, 3'd1, 3'd1, 1'b0, 16'd0,     32'd0,         1'b1};
        vecs[4]  = '{3'b011, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0,     32'd4,         1'b0};
        vecs[5]  = '{3'b100, 3'd6, 3'd1, 3'd2, 1'b0, 16'd0,     32'd17,        1'b0};
        vecs[6]  = '{3'b010, 3'd7, 3'd0, 3'd0, 1'b1, 16'd1,     32'hFFFFFFFF,  1'b0};
        vecs[7]  = '{3'b110, 3'd7, 3'd7, 3'd0, 1'b1, 16'd5,     32'h07FFFFFF,  1'b0};
        vecs[8]  = '{3'b101, 3'd1, 3'd1, 3'd0, 1'b1, 16'd3,     32'd160,       1'b0};
        vecs[9]  = '{3'b001, 3'd0, 3'd1, 3'd0, 1'b1, 16'd0,     32'd0,         1'b0};
        vecs[10] = '{3'b001, 3'd0, 3'd0, 3'd0, 1'b1, 16'd0,     32'd0,         1'b1};
        vecs[11] = '{3'b001, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFD,  32'hFFFFFFFD,  1'b0};

        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check1("rst_in_ready", in_ready, 1'b1);
        check32("rst_alu_a", alu_a, 32'd0);
        check32("rst_alu_b", alu_b, 32'd0);
        check32("rst_alu_sel", 32'(alu_sel), 32'd0);
        check1("rst_z_flag", z_flag, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check32("rst_regfile", dbg_data, 32'd0);
        end

        // Directed table, issued back-to-back (each accepted in the previous WB)
        for (int i = 0; i < 12; i++) begin
            model_step(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].use_imm, vecs[i].imm, ev, ez, ee);
            run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].use_imm, vecs[i].imm,
                      vecs[i].exp_val, vecs[i].exp_z, 1'b0);
        end
        drain();

        // Reset asserted during EXEC of ADD r2,r0,#9 aborts it
        in_valid = 1'b1; in_op = 3'b001; in_rd = 3'd2; in_rs1 = 3'd0; in_rs2 = 3'd0;
        in_use_imm = 1'b1; in_imm = 16'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        dbg_addr = 3'd2;
        #1;
        check1("abort_in_ready", in_ready, 1'b1);
        check1("abort_done", done, 1'b0);
        check32("abort_r2", dbg_data, 32'd0);
        check32("abort_alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check1("abort_no_done", done, 1'b0);
        end
        dbg_addr = 3'd2;
        #1;
        check32("abort_r2_after", dbg_data, 32'd0);
        check1("abort_z_flag", z_flag, 1'b0);
        model_reset();

        // Illegal op 111 on r3 after setting r3 = 7
        model_step(3'b001, 3'd3, 3'd0, 3'd0, 1'b1, 16'd7, ev, ez, ee);
        run_instr(3'b001, 3'd3, 3'd0, 3'd0, 1'b1, 16'd7, ev, ez, ee);
        model_step(3'b111, 3'd3, 3'd3, 3'd3, 1'b0, 16'd0, ev, ez, ee);
        run_instr(3'b111, 3'd3, 3'd3, 3'd3, 1'b0, 16'd0, ev, ez, ee);
        drain();

        // Randomized instructions with occasional idle gaps
        for (int n = 0; n < 60; n++) begin
            r_op  = 3'($urandom_range(7, 0));
            r_rd  = 3'($urandom_range(7, 0));
            r_rs1 = 3'($urandom_range(7, 0));
            r_rs2 = 3'($urandom_range(7, 0));
            r_ui  = 1'($urandom_range(1, 0));
            r_imm = 16'($urandom);
            model_step(r_op, r_rd, r_rs1, r_rs2, r_ui, r_imm, ev, ez, ee);
            run_instr(r_op, r_rd, r_rs1, r_rs2, r_ui, r_imm, ev, ez, ee);
            if ($urandom_range(3, 0) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check32("final_regfile", dbg_data, ref_regs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
